// File: rtl/color_freq_gen.sv
// Emulated colour-sensor frequency output: a select-driven square wave generator
// with per-channel programmable half-periods, settle blanking and output enable.
module color_freq_gen #(
  parameter int unsigned SETTLE_CYC = 1000,
  parameter logic [23:0] RST_HALF_R = 24'd5000,
  parameter logic [23:0] RST_HALF_B = 24'd8000,
  parameter logic [23:0] RST_HALF_G = 24'd6500,
  parameter logic [23:0] RST_HALF_C = 24'd2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select0,
  input  logic        select1,
  input  logic        select2,
  input  logic        select3,
  input  logic        EO,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_chan,
  input  logic [23:0] cfg_half,
  output logic        cfg_ready,
  output logic        freqIn,
  output logic [1:0]  active_chan,
  output logic [15:0] edge_cnt
);

  localparam int unsigned SETTLE_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int unsigned SCW         = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Selects packed as {scale, channel}: scale = {select0, select1}, channel = {select2, select3}
  logic [3:0] sel_raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] sel_prev_q;
  logic [1:0] sel_scale;
  logic [1:0] sel_chan;
  logic       power_down;
  logic       sel_changed;

  assign sel_raw     = {select0, select1, select2, select3};
  assign sel_scale   = sync2_q[3:2];
  assign sel_chan    = sync2_q[1:0];
  assign power_down  = (sel_scale == 2'b00);
  assign sel_changed = (sync2_q != sel_prev_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sel_prev_q <= '0;
    end else begin
      sync1_q    <= sel_raw;
      sync2_q    <= sync1_q;
      sel_prev_q <= sync2_q;
    end
  end

  logic        cfg_ready_q;
  logic        cfg_wr;
  logic [23:0] cfg_half_clamp;

  assign cfg_wr         = cfg_valid & cfg_ready_q;
  assign cfg_half_clamp = (cfg_half == 24'd0) ? 24'd1 : cfg_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_ready_q <= 1'b0;
    else     cfg_ready_q <= 1'b1;
  end

  function automatic logic [23:0] rst_half(input int unsigned idx);
    case (idx)
      0:       rst_half = RST_HALF_R;
      1:       rst_half = RST_HALF_B;
      2:       rst_half = RST_HALF_C;
      default: rst_half = RST_HALF_G;
    endcase
  endfunction

  logic [23:0] half_rd [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_half
    logic [23:0] half_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        half_q <= rst_half(gi);
      end else if (cfg_wr && (cfg_chan == 2'(gi))) begin
        half_q <= cfg_half_clamp;
      end
    end
    assign half_rd[gi] = half_q;
  end

  logic [1:0]  active_chan_q, active_chan_d;
  logic [29:0] h_ext;
  logic [29:0] eff_calc;

  // 24-bit base times at most 50 stays below 2^30, so the product never truncates
  assign h_ext = {6'd0, half_rd[active_chan_q]};

  always_comb begin
    eff_calc = h_ext;
    case (sel_scale)
      2'b10:   eff_calc = h_ext * 30'd5;
      2'b01:   eff_calc = h_ext * 30'd50;
      default: eff_calc = h_ext;
    endcase
  end

  state_t          state_q, state_d;
  logic [SCW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [29:0]     half_cnt_q, half_cnt_d;
  logic [29:0]     eff_q, eff_d;
  logic            wave_q, wave_d;
  logic [15:0]     edge_cnt_q, edge_cnt_d;
  logic            freq_q;

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    half_cnt_d    = half_cnt_q;
    eff_d         = eff_q;
    wave_d        = wave_q;
    edge_cnt_d    = edge_cnt_q;
    active_chan_d = active_chan_q;

    if (power_down) begin
      state_d      = ST_OFF;
      settle_cnt_d = '0;
      half_cnt_d   = '0;
      wave_d       = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d       = ST_SETTLE;
          settle_cnt_d  = '0;
          half_cnt_d    = '0;
          wave_d        = 1'b0;
          active_chan_d = sel_chan;
        end
        ST_SETTLE: begin
          if (sel_changed) begin
            settle_cnt_d  = '0;
            active_chan_d = sel_chan;
          end else if (settle_cnt_q == SCW'(SETTLE_LAST)) begin
            state_d      = ST_RUN;
            settle_cnt_d = '0;
            half_cnt_d   = '0;
            wave_d       = 1'b0;
            eff_d        = eff_calc;
          end else begin
            settle_cnt_d = settle_cnt_q + SCW'(1);
          end
        end
        ST_RUN: begin
          if (sel_changed) begin
            state_d       = ST_SETTLE;
            settle_cnt_d  = '0;
            half_cnt_d    = '0;
            wave_d        = 1'b0;
            active_chan_d = sel_chan;
          end else if (half_cnt_q == eff_q - 30'd1) begin
            // Relatching here lets new configuration land only on a half-cycle boundary
            wave_d     = ~wave_q;
            half_cnt_d = '0;
            eff_d      = eff_calc;
            if (!wave_q) edge_cnt_d = edge_cnt_q + 16'd1;
          end else begin
            half_cnt_d = half_cnt_q + 30'd1;
          end
        end
        default: begin
          state_d      = ST_OFF;
          settle_cnt_d = '0;
          half_cnt_d   = '0;
          wave_d       = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      settle_cnt_q  <= '0;
      half_cnt_q    <= '0;
      eff_q         <= '0;
      wave_q        <= 1'b0;
      edge_cnt_q    <= '0;
      active_chan_q <= 2'b00;
      freq_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      half_cnt_q    <= half_cnt_d;
      eff_q         <= eff_d;
      wave_q        <= wave_d;
      edge_cnt_q    <= edge_cnt_d;
      active_chan_q <= active_chan_d;
      freq_q        <= wave_q & ~EO;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign freqIn      = freq_q;
  assign active_chan = active_chan_q;
  assign edge_cnt    = edge_cnt_q;

endmodule

// File: tb/tb_color_freq_gen.sv
// Self-checking bench for color_freq_gen: deadline-based reference model compared
// every cycle, plus directed scenarios with hand-computed latencies and half-periods.
module tb_color_freq_gen;

  localparam int unsigned SETTLE = 20;
  localparam int unsigned HR = 50;
  localparam int unsigned HB = 80;
  localparam int unsigned HG = 65;
  localparam int unsigned HC = 25;

  logic        clk;
  logic        rst;
  logic        select0, select1, select2, select3;
  logic        EO;
  logic        cfg_valid;
  logic [1:0]  cfg_chan;
  logic [23:0] cfg_half;
  logic        cfg_ready;
  logic        freqIn;
  logic [1:0]  active_chan;
  logic [15:0] edge_cnt;

  int checks;
  int failures;

  color_freq_gen #(
    .SETTLE_CYC (SETTLE),
    .RST_HALF_R (24'(HR)),
    .RST_HALF_B (24'(HB)),
    .RST_HALF_G (24'(HG)),
    .RST_HALF_C (24'(HC))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .select0     (select0),
    .select1     (select1),
    .select2     (select2),
    .select3     (select3),
    .EO          (EO),
    .cfg_valid   (cfg_valid),
    .cfg_chan    (cfg_chan),
    .cfg_half    (cfg_half),
    .cfg_ready   (cfg_ready),
    .freqIn      (freqIn),
    .active_chan (active_chan),
    .edge_cnt    (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: tracks absolute cycle deadlines rather than counters
  longint      cyc;
  logic [3:0]  m_s1, m_s2, m_prev;
  int          m_mode;            // 0 power-down, 1 blanking, 2 oscillating
  longint      m_settle_end, m_toggle_at;
  int unsigned m_half [4];
  logic        m_wave, m_freq, m_rdy;
  logic [1:0]  m_chan;
  logic [15:0] m_edges;

  function automatic int unsigned m_eff(input logic [1:0] scale, input int unsigned h);
    case (scale)
      2'b10:   return h * 5;
      2'b01:   return h * 50;
      default: return h;
    endcase
  endfunction

  task automatic m_reset();
    m_half[0] = HR; m_half[1] = HB; m_half[2] = HC; m_half[3] = HG;
    m_s1 = '0; m_s2 = '0; m_prev = '0;
    m_mode = 0; m_wave = 1'b0; m_freq = 1'b0; m_rdy = 1'b0;
    m_chan = 2'b00; m_edges = '0;
    m_settle_end = 0; m_toggle_at = 0;
  endtask

  initial begin
    cyc = 0;
    m_reset();
  end

  always @(posedge clk) begin
    logic [3:0] old_s2;
    logic [1:0] sc;
    logic       old_rdy;
    if (rst) begin
      m_reset();
    end else begin
      old_s2  = m_s2;
      old_rdy = m_rdy;
      sc      = old_s2[3:2];
      m_freq  = m_wave & ~EO;
      if (sc == 2'b00) begin
        m_mode = 0;
        m_wave = 1'b0;
      end else if (m_mode == 0 || old_s2 != m_prev) begin
        m_mode       = 1;
        m_settle_end = cyc + SETTLE;
        m_chan       = old_s2[1:0];
        m_wave       = 1'b0;
      end else if (m_mode == 1 && cyc == m_settle_end) begin
        m_mode      = 2;
        m_wave      = 1'b0;
        m_toggle_at = cyc + m_eff(sc, m_half[m_chan]);
      end else if (m_mode == 2 && cyc == m_toggle_at) begin
        if (!m_wave) m_edges = m_edges + 16'd1;
        m_wave      = ~m_wave;
        m_toggle_at = cyc + m_eff(sc, m_half[m_chan]);
      end
      if (cfg_valid && old_rdy) m_half[cfg_chan] = (cfg_half == 24'd0) ? 1 : int'(cfg_half);
      m_rdy  = 1'b1;
      m_prev = old_s2;
      m_s2   = m_s1;
      m_s1   = {select0, select1, select2, select3};
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_freqIn", longint'(freqIn), longint'(m_freq));
      check("cyc_edge_cnt", longint'(edge_cnt), longint'(m_edges));
      check("cyc_active_chan", longint'(active_chan), longint'(m_chan));
      check("cyc_cfg_ready", longint'(cfg_ready), longint'(m_rdy));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] scale, input logic [1:0] ch);
    select0 = scale[1];
    select1 = scale[0];
    select2 = ch[1];
    select3 = ch[0];
  endtask

  task automatic wait_rise(input string name, input int budget, output int n);
    logic prev;
    logic found;
    prev  = freqIn;
    found = 1'b0;
    n     = 0;
    while (!found && n < budget) begin
      tick();
      n++;
      if (!prev && freqIn) found = 1'b1;
      prev = freqIn;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no rising edge within %0d cycles", name, budget);
    end
  endtask

  task automatic count_level(input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (freqIn == lvl && n < budget);
  endtask

  initial begin
    int n;
    int hits;
    logic [15:0] e0;

    checks = 0; failures = 0;
    rst = 1'b1; EO = 1'b0;
    cfg_valid = 1'b0; cfg_chan = 2'b00; cfg_half = 24'd0;
    set_sel(2'b11, 2'b00);
    repeat (3) tick();
    check("rst_freqIn", freqIn, 0);
    check("rst_edge_cnt", edge_cnt, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_active_chan", active_chan, 0);
    $display("txn reset: freqIn=%0d edge_cnt=%0d cfg_ready=%0d", freqIn, edge_cnt, cfg_ready);

    // Red at 100%: rise 2+20+50+1 edges after the sampling edge
    rst = 1'b0;
    wait_rise("red_start", 200, n);
    check("red_latency", n, 74);
    check("cfg_ready_run", cfg_ready, 1);
    count_level(1'b1, 200, n); check("red_high", n, 50);
    count_level(1'b0, 200, n); check("red_low", n, 50);
    $display("txn red 100%%: latency/high/low measured, edge_cnt=%0d", edge_cnt);

    set_sel(2'b11, 2'b01);
    wait_rise("blue_start", 400, n);
    check("blue_latency", n, 104);
    check("blue_chan", active_chan, 1);
    count_level(1'b1, 200, n); check("blue_high", n, 80);
    $display("txn blue 100%%: chan=%0d", active_chan);

    set_sel(2'b10, 2'b11);
    wait_rise("green20_start", 600, n);
    check("green20_latency", n, 349);
    count_level(1'b1, 600, n); check("green20_high", n, 325);
    $display("txn green 20%%: chan=%0d", active_chan);

    set_sel(2'b01, 2'b11);
    wait_rise("green2_start", 5000, n);
    check("green2_latency", n, 3274);
    count_level(1'b1, 5000, n); check("green2_high", n, 3250);
    $display("txn green 2%%");

    set_sel(2'b00, 2'b11);
    repeat (5) tick();
    hits = 0;
    repeat (300) begin tick(); if (freqIn) hits++; end
    check("powerdown_quiet", hits, 0);
    $display("txn power-down: high samples=%0d", hits);

    // Red again; mid-half writes to red (active) and clear (inactive)
    set_sel(2'b11, 2'b00);
    wait_rise("red2_start", 200, n);
    check("red2_latency", n, 74);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 10) begin cfg_valid = 1'b1; cfg_chan = 2'b00; cfg_half = 24'd20; end
      if (n == 11) cfg_valid = 1'b0;
      if (n == 20) begin cfg_valid = 1'b1; cfg_chan = 2'b10; cfg_half = 24'd7; end
      if (n == 21) cfg_valid = 1'b0;
    end while (freqIn && n < 200);
    cfg_valid = 1'b0;
    check("wr_current_half", n, 50);
    count_level(1'b0, 200, n); check("wr_new_low", n, 20);
    count_level(1'b1, 200, n); check("wr_new_high", n, 20);
    $display("txn cfg write red=20 mid-half, clear=7");

    EO = 1'b1;
    e0 = edge_cnt;
    hits = 0;
    repeat (120) begin tick(); if (freqIn) hits++; end
    check("eo_quiet", hits, 0);
    check("eo_edges", 16'(edge_cnt - e0), 3);
    EO = 1'b0;
    wait_rise("eo_resume", 100, n);
    count_level(1'b1, 100, n); check("eo_resume_high", n, 20);
    $display("txn EO blanking: edges advanced=%0d", 16'(edge_cnt - e0));

    cfg_valid = 1'b1; cfg_chan = 2'b00; cfg_half = 24'd0;
    tick();
    cfg_valid = 1'b0;
    repeat (60) tick();
    wait_rise("half1_rise", 10, n);
    count_level(1'b1, 10, n); check("half1_high", n, 1);
    count_level(1'b0, 10, n); check("half1_low", n, 1);
    $display("txn cfg_half=0 -> half-period 1");

    rst = 1'b1;
    #1;
    check("midrst_freqIn", freqIn, 0);
    check("midrst_edge_cnt", edge_cnt, 0);
    check("midrst_cfg_ready", cfg_ready, 0);
    repeat (2) tick();
    rst = 1'b0;
    wait_rise("post_rst", 200, n);
    check("post_rst_latency", n, 74);
    count_level(1'b1, 200, n); check("post_rst_red_high", n, 50);
    $display("txn reset mid-run: red half restored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
